// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   Receives 8N1 UART frames from an asynchronous serial line and buffers the
//   bytes in a first-word-fall-through FIFO for a ready/valid consumer.
//
// Parameters
//   BAUD_DIV    clocks per UART bit (8..65535)
//   FIFO_DEPTH  received-byte buffer entries (power of two, 2..256)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_i         serial line, idle high, asynchronous to clk
//   data_o       byte at FIFO head (0 while empty after reset)
//   valid_o      FIFO not empty
//   ready_i      consumer accepts data_o; pop on valid_o & ready_i
//   frame_err_o  one-cycle pulse after a stop bit sampled low
//   overflow_o   sticky, a byte was dropped because the FIFO was full
//   clr_i        synchronous clear of overflow_o
//   level_o      current FIFO occupancy, 0..FIFO_DEPTH
module uart_rx_capture #(
    parameter int BAUD_DIV   = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx_i,
    output logic [7:0]                         data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               frame_err_o,
    output logic                               overflow_o,
    input  logic                               clr_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    // Counter runs from 0 after each clear, so a sample lands when it
    // reaches N-1 (N clocks after the clearing cycle).
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ferr_d;
    logic        push;

    logic rx_meta, rx_s, rx_prev;

    // Two-flop synchronizer plus one history flop for falling-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_o <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // Line held low after a bad stop: ignore it until it idles.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic          full, pop, wr_en, drop;

    assign valid_o = (level_q != '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign pop     = valid_o & ready_i;
    // A full FIFO still accepts the byte when the head leaves the same cycle.
    assign wr_en   = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign level_o = level_q;
    assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            level_q <= level_q + LW'(wr_en) - LW'(pop);
            // A drop in the clearing cycle keeps the flag set.
            if (drop)       overflow_o <= 1'b1;
            else if (clr_i) overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: drives directed UART frames, keeps a queue-based
// model of the receive FIFO fed by frame arrival times computed from the
// frame start, and compares every cycle; literal checks pin the model.
module tb_uart_rx_capture;

    localparam int B     = 32;
    localparam int H     = B / 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n, rx_i, ready_i, clr_i;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overflow_o;
    logic [4:0] level_o;

    uart_rx_capture #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .frame_err_o(frame_err_o),
        .overflow_o(overflow_o), .clr_i(clr_i), .level_o(level_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------------------------------------------------- model
    typedef struct {
        int         edge_n;   // posedge at which the byte becomes visible
        bit         good;     // stop bit was 1
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    bit         m_ovf = 0, pop_p = 0, clr_p = 0, exp_ferr = 0;
    int         ferr_cnt = 0;
    ev_t        ev;
    logic [7:0] junk;

    always @(negedge clk) begin
        bit full, drop, hit;
        if (!rst_n) begin
            mq.delete();
            evq.delete();
            m_ovf = 0;
            chk("rst_valid", int'(valid_o), 0);
            chk("rst_level", int'(level_o), 0);
            chk("rst_data", int'(data_o), 0);
            chk("rst_ovf", int'(overflow_o), 0);
            chk("rst_ferr", int'(frame_err_o), 0);
        end else begin
            hit = 0;
            if (evq.size() > 0 && evq[0].edge_n == cyc) begin
                hit = 1;
                ev  = evq.pop_front();
            end
            full = (mq.size() == DEPTH);
            drop = 0;
            if (pop_p) junk = mq.pop_front();
            if (hit && ev.good) begin
                if (!full || pop_p) mq.push_back(ev.data);
                else drop = 1;
            end
            exp_ferr = hit && !ev.good;
            if (drop) m_ovf = 1;
            else if (clr_p) m_ovf = 0;

            chk("valid", int'(valid_o), int'(mq.size() != 0));
            chk("level", int'(level_o), mq.size());
            chk("ovf", int'(overflow_o), int'(m_ovf));
            chk("ferr", int'(frame_err_o), int'(exp_ferr));
            if (mq.size() != 0) chk("data", int'(data_o), int'(mq[0]));
            if (valid_o && ready_i) popped.push_back(data_o);
            if (frame_err_o) ferr_cnt++;
        end
        pop_p = rst_n && (mq.size() != 0) && ready_i;
        clr_p = rst_n && clr_i;
    end

    // ---------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line goes low just after edge k; the synchronizer sees it two edges
    // later (T0), the stop sample lands H+9B cycles after T0 and the byte is
    // visible after the following edge.
    task automatic send(input logic [7:0] d, input bit stop = 1'b1,
                        input int hold = 0, input bit rpulse = 1'b0);
        ev_t e;
        e.edge_n = cyc + 3 + H + 9 * B;
        e.good   = stop;
        e.data   = d;
        evq.push_back(e);
        rx_i = 1'b0;
        repeat (B) tick();
        for (int j = 0; j < 8; j++) begin
            rx_i = d[j];
            repeat (B) tick();
        end
        rx_i = stop;
        for (int i = 1; i <= B; i++) begin
            tick();
            if (rpulse && i == 2 + H) ready_i = 1'b1;
            if (rpulse && i == 3 + H) ready_i = 1'b0;
        end
        if (!stop) repeat (hold) tick();
        rx_i = 1'b1;
    endtask

    task automatic drain(input int n);
        ready_i = 1'b1;
        repeat (n) tick();
        ready_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0; clr_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        // single frame, held in FIFO
        ferr_cnt = 0;
        send(8'h55);
        repeat (4) tick();
        chk("f55_valid", int'(valid_o), 1);
        chk("f55_data", int'(data_o), 8'h55);
        chk("f55_level", int'(level_o), 1);
        chk("f55_noferr", ferr_cnt, 0);
        drain(2);
        chk("f55_drained", int'(level_o), 0);

        // start glitch of 8 clocks
        rx_i = 1'b0;
        repeat (8) tick();
        rx_i = 1'b1;
        repeat (40) tick();
        chk("glitch_valid", int'(valid_o), 0);
        chk("glitch_level", int'(level_o), 0);

        // framing error followed by a long break, then a good frame
        ferr_cnt = 0;
        send(8'hA3, 1'b0, 100);
        repeat (5) tick();
        chk("ferr_once", ferr_cnt, 1);
        chk("ferr_nopush", int'(level_o), 0);
        send(8'h3C);
        repeat (4) tick();
        chk("f3c_data", int'(data_o), 8'h3C);
        chk("f3c_level", int'(level_o), 1);
        drain(2);

        // 17 back-to-back frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send(8'(i));
        repeat (4) tick();
        chk("ovf_level", int'(level_o), 16);
        chk("ovf_set", int'(overflow_o), 1);
        popped.delete();
        drain(20);
        chk("ovf_sticky", int'(overflow_o), 1);
        chk("ovf_popcnt", popped.size(), 16);
        for (int i = 0; i < 16 && i < popped.size(); i++)
            chk("ovf_order", int'(popped[i]), i);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        chk("ovf_clr", int'(overflow_o), 0);

        // full FIFO with a pop in the push cycle
        popped.delete();
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
        send(8'h30, 1'b1, 0, 1'b1);
        repeat (4) tick();
        chk("fullpp_level", int'(level_o), 16);
        chk("fullpp_noovf", int'(overflow_o), 0);
        drain(20);
        chk("fullpp_popcnt", popped.size(), 17);
        for (int i = 0; i < 17 && i < popped.size(); i++)
            chk("fullpp_order", int'(popped[i]), 8'h20 + i);

        // reset in the middle of data bit 4 of a 0x5A frame
        send(8'h11);
        repeat (4) tick();
        chk("prerst_level", int'(level_o), 1);
        rx_i = 1'b0;
        repeat (B) tick();
        for (int j = 0; j < 4; j++) begin
            rx_i = j[0] ? 1'b1 : 1'b0;   // 0x5A bits 0..3 = 0,1,0,1
            repeat (B) tick();
        end
        rx_i = 1'b1;                      // bit 4 of 0x5A
        repeat (H) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_level", int'(level_o), 0);
        chk("postrst_valid", int'(valid_o), 0);
        repeat (10 * B) tick();
        chk("postrst_nofalse", int'(level_o), 0);
        send(8'h7E);
        repeat (4) tick();
        chk("f7e_data", int'(data_o), 8'h7E);
        chk("f7e_level", int'(level_o), 1);
        drain(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
